// File: rtl/neural_soc_pio_pkg.sv
// Shared constants for the neural SoC input PIO: register offsets and edge-capture modes.
package neural_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Picks the capture-set pulse for one bit from its committed rise/fall pulses.
    function automatic logic edge_select(input int mode, input logic rise, input logic fall);
        logic sel;
        case (mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            default:   sel = rise | fall;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/neural_soc_pio_debounce.sv
// One input bit: 2-flop synchroniser, mismatch counter and stable level, with
// single-cycle rise/fall pulses that are high on the cycle before stb changes.
module neural_soc_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stb,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             commit;

    // commit is true on the cycle whose edge loads s2 into stb.
    assign commit = (s2 != stb) && (cnt == CNT_LAST);
    assign rise   = commit &  s2;
    assign fall   = commit & ~s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            stb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == stb) begin
                cnt <= '0;
            end else if (commit) begin
                stb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/neural_soc_pio_in.sv
// Avalon-MM input PIO slave: debounced DATA, IRQMASK and write-1-to-clear EDGECAPTURE,
// with a level interrupt taken straight from the mask and capture registers.
module neural_soc_pio_in
    import neural_soc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = EDGE_FALL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stb;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      rd_mux;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        neural_soc_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .stb     (stb[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
        assign set_bits[i] = edge_select(EDGE_MODE, rise[i], fall[i]);
    end

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    // Bus protocol: no waitrequest. A write is accepted on any edge where
    // chipselect=1 and write_n=0; readdata always reflects the address of the
    // previous cycle, whether or not chipselect was asserted.
    assign wr_en    = chipselect & ~write_n;
    assign clr_bits = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stb;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            if (wr_en && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // A new capture outranks a clear of the same bit in the same cycle.
            edgecapture <= (edgecapture & ~clr_bits) | set_bits;
            readdata    <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_neural_soc_pio_in.sv
// Bench for neural_soc_pio_in: four instances (falling/rising/any edge at 4 bits,
// falling edge at 32 bits) on one shared bus, compared every cycle against a window model.
`timescale 1ns/1ps
module tb_neural_soc_pio_in;
    import neural_soc_pio_pkg::*;

    localparam int D    = 16;
    localparam int NDUT = 4;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      in_raw;
    logic [3:0][31:0] rd_obs;
    logic [3:0]       irq_obs;

    int checks   = 0;
    int failures = 0;

    // Reference state: stable value, capture, mask, expected readdata and irq per instance.
    logic [31:0] m_stb  [NDUT];
    logic [31:0] m_cap  [NDUT];
    logic [31:0] m_mask [NDUT];
    logic [31:0] m_rd   [NDUT];
    logic        m_irq  [NDUT];
    logic [31:0] hist[$];

    neural_soc_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_FALL)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_raw[3:0]),
        .readdata(rd_obs[0]), .irq(irq_obs[0]));

    neural_soc_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_RISE)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_raw[3:0]),
        .readdata(rd_obs[1]), .irq(irq_obs[1]));

    neural_soc_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_ANY)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_raw[3:0]),
        .readdata(rd_obs[2]), .irq(irq_obs[2]));

    neural_soc_pio_in #(.WIDTH(32), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_FALL)) u_w32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_raw),
        .readdata(rd_obs[3]), .irq(irq_obs[3]));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wmask(input int i);
        return (i == 3) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction

    function automatic int mode(input int i);
        case (i)
            1:       return EDGE_RISE;
            2:       return EDGE_ANY;
            default: return EDGE_FALL;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The raw history holds the last D+2 sampled inputs; zeros stand for the cleared synchroniser.
    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(32'h0);
        for (int i = 0; i < NDUT; i++) begin
            m_stb[i]  = '0;
            m_cap[i]  = '0;
            m_mask[i] = '0;
            m_rd[i]   = '0;
            m_irq[i]  = 1'b0;
        end
    endtask

    // One clock: a level is accepted once the D samples seen through the
    // two-stage synchroniser all disagree with the current stable level.
    task automatic tick();
        logic [31:0] andw, orw, nstb, chg, setb, clr, wd;
        logic        wr;
        hist.push_back(in_raw);
        andw = '1;
        orw  = '0;
        for (int k = 1; k <= D; k++) begin
            andw &= hist[k];
            orw  |= hist[k];
        end
        void'(hist.pop_front());
        wr = chipselect && !write_n;
        for (int i = 0; i < NDUT; i++) begin
            nstb = ((m_stb[i] & orw) | (~m_stb[i] & andw)) & wmask(i);
            chg  = nstb ^ m_stb[i];
            case (mode(i))
                EDGE_RISE: setb = chg & nstb;
                EDGE_FALL: setb = chg & ~nstb;
                default:   setb = chg;
            endcase
            wd  = writedata & wmask(i);
            clr = (wr && address == 2'd3) ? wd : 32'h0;
            case (address)
                2'd0:    m_rd[i] = m_stb[i];
                2'd2:    m_rd[i] = m_mask[i];
                2'd3:    m_rd[i] = m_cap[i];
                default: m_rd[i] = 32'h0;
            endcase
            m_cap[i] = (m_cap[i] & ~clr) | setb;
            if (wr && address == 2'd2) m_mask[i] = wd;
            m_stb[i] = nstb;
            m_irq[i] = |(m_cap[i] & m_mask[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rd_dut%0d", i), rd_obs[i], m_rd[i]);
            check($sformatf("irq_dut%0d", i), {31'b0, irq_obs[i]}, {31'b0, m_irq[i]});
        end
    endtask

    // Driver tasks
    task automatic bus_idle(input logic [1:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        bus_idle(a);
    endtask

    task automatic read_reg(input logic [1:0] a, input int idx, output logic [31:0] v);
        bus_idle(a);
        tick();
        v = rd_obs[idx];
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_rd%0d", tag, i), rd_obs[i], 32'h0);
            check($sformatf("%s_irq%0d", tag, i), {31'b0, irq_obs[i]}, 32'h0);
        end
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          n;

        // Power-on reset
        reset_n = 1'b0;
        in_raw  = 32'hFFFF_FFFF;
        bus_idle(2'd0);
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Run with keys high and mask set, then reset mid-operation.
        bus_write(2'd2, 32'hF);
        repeat (D + 5) tick();
        check("pre_reset_data", rd_obs[0], 32'hF);
        do_reset("mid_rst");

        // Keys held high at reset commit a rising change after debounce.
        bus_idle(2'd0);
        for (int t = 1; t <= D + 3; t++) begin
            tick();
            if (t == D + 2) check("rst_lat_early", rd_obs[0], 32'h0);
            if (t == D + 3) check("rst_lat_data", rd_obs[0], 32'hF);
        end
        read_reg(2'd3, 0, v);
        check("rst_cap_fall", v, 32'h0);

        // Glitch one cycle shorter than the debounce window.
        bus_idle(2'd0);
        in_raw = 32'hFFFF_FFFE;
        repeat (D - 1) tick();
        in_raw = 32'hFFFF_FFFF;
        repeat (20) tick();
        check("glitch_data", rd_obs[0], 32'hF);
        check("glitch_irq", {31'b0, irq_obs[0]}, 32'h0);
        read_reg(2'd3, 0, v);
        check("glitch_cap", v, 32'h0);

        // Press bit 2 with only bit 2 unmasked.
        bus_write(2'd2, 32'h4);
        bus_idle(2'd0);
        in_raw = 32'hFFFF_FFFB;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == D + 1) check("press_irq_before", {31'b0, irq_obs[0]}, 32'h0);
            if (t == D + 2) check("press_irq_edge", {31'b0, irq_obs[0]}, 32'h1);
            if (t == D + 2) check("press_data_before", rd_obs[0], 32'hF);
            if (t == D + 3) check("press_data", rd_obs[0], 32'hB);
        end
        read_reg(2'd3, 0, v);
        check("press_cap", v, 32'h4);
        in_raw = 32'hFFFF_FFFF;
        repeat (D + 9) tick();

        // Write-1-to-clear: wrong bit leaves the capture, right bit drops irq on the write edge.
        bus_write(2'd3, 32'h1);
        read_reg(2'd3, 0, v);
        check("clear_other_bit", v, 32'h4);
        bus_write(2'd3, 32'h4);
        check("clear_irq", {31'b0, irq_obs[0]}, 32'h0);
        read_reg(2'd3, 0, v);
        check("clear_cap", v, 32'h0);

        // Clear bit 1 on the very cycle its falling change commits.
        bus_idle(2'd3);
        in_raw = 32'hFFFF_FFFD;
        repeat (D + 1) tick();
        bus_write(2'd3, 32'h2);
        read_reg(2'd3, 0, v);
        check("collision_cap", v, 32'h2);

        // Capture with mask clear, then unmask.
        bus_write(2'd2, 32'h0);
        bus_idle(2'd0);
        in_raw = 32'hFFFF_FFF5;
        repeat (D + 4) tick();
        check("masked_irq", {31'b0, irq_obs[0]}, 32'h0);
        read_reg(2'd3, 0, v);
        check("masked_cap", v, 32'hA);
        bus_write(2'd2, 32'hF);
        check("unmask_irq", {31'b0, irq_obs[0]}, 32'h1);

        // Reset part-way through a debounce: the pending change is dropped.
        bus_idle(2'd0);
        in_raw = 32'hFFFF_FFFE;
        repeat (8) tick();
        do_reset("dbnc_rst");
        bus_idle(2'd0);
        repeat (D + 6) tick();
        check("dbnc_rst_data", rd_obs[0], 32'hE);
        read_reg(2'd3, 0, v);
        check("dbnc_rst_cap", v, 32'h0);

        // Random input levels and bus traffic against the model.
        for (int s = 0; s < 40; s++) begin
            in_raw = $urandom();
            n = $urandom_range(1, 2 * D + 4);
            for (int t = 0; t < n; t++) begin
                address    = 2'($urandom_range(0, 3));
                chipselect = 1'($urandom_range(0, 1));
                write_n    = ($urandom_range(0, 3) != 0);
                writedata  = $urandom();
                tick();
            end
        end
        bus_idle(2'd0);
        repeat (4) tick();

        // Report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
